td4_prog_rom: RTL and testbench

- Program-memory responder for the TD4 CPU core.
- The CPU core is the fetch initiator: it presents a 4-bit PC and requests an instruction.
- This block answers each fetch with one registered 8-bit instruction word.
- It also accepts a byte-serial program download from the chip pins (ui_in/uio_in) and holds the CPU while a download is in progress.

---
 rtl/td4_prog_rom_if.sv | 35 +++
 rtl/td4_prog_rom.sv | 126 ++++++++++++
 tb/tb_td4_prog_rom.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/td4_prog_rom_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | td4_prog_rom_if : program-download and instruction-fetch bus         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface td4_prog_rom_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic          load_en;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_ready;
   logic          load_done;
   logic          load_abort;
   logic          cpu_hold;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic [DW-1:0] fetch_data;
   logic          fetch_valid;
   logic [DW-1:0] checksum;

   modport master (
      output load_en, load_valid, load_data, fetch_req, fetch_addr,
      input  load_ready, load_done, load_abort, cpu_hold,
             fetch_data, fetch_valid, checksum
   );

   modport slave (
      input  load_en, load_valid, load_data, fetch_req, fetch_addr,
      output load_ready, load_done, load_abort, cpu_hold,
             fetch_data, fetch_valid, checksum
   );
endinterface
`default_nettype wire

// File: rtl/td4_prog_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | td4_prog_rom : TD4 program memory with byte-serial download port     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module td4_prog_rom #(
   parameter int            AW       = 4,
   parameter int            DW       = 8,
   parameter logic [DW-1:0] RST_WORD = '0
) (
   input  logic          clk,
   input  logic          rst,
   td4_prog_rom_if.slave bus
);

   localparam int           c_DEPTH    = 2**AW;
   localparam logic [AW:0]  c_LAST_PTR = {1'b0, {AW{1'b1}}};
   localparam logic [AW:0]  c_PTR_ONE  = {{AW{1'b0}}, 1'b1};

   localparam logic [0:0]   c_ST_RUN   = 1'b0;
   localparam logic [0:0]   c_ST_LOAD  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [DW-1:0] mem_q [c_DEPTH];
   logic [AW:0]   wptr_q;
   logic [DW-1:0] checksum_q;
   logic [DW-1:0] fetch_data_q;
   logic          fetch_valid_q;
   logic          load_done_q;
   logic          load_abort_q;
   // Cleared by a completed download; load_en must drop before another starts.
   logic          armed_q;

   logic          w_in_load;
   logic          w_start;
   logic          w_wr;
   logic          w_last;
   logic          w_fetch;
   logic          w_load_ready;
   logic          w_cpu_hold;

   assign w_in_load = (state_q == c_ST_LOAD);
   assign w_start   = (state_q == c_ST_RUN) && bus.load_en && armed_q;
   assign w_wr      = w_in_load && bus.load_en && bus.load_valid;
   assign w_last    = (wptr_q == c_LAST_PTR);
   assign w_fetch   = (state_q == c_ST_RUN) && bus.fetch_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_RUN: begin
            if (w_start) begin
               state_d = c_ST_LOAD;
            end
         end
         c_ST_LOAD: begin
            if (!bus.load_en || (w_wr && w_last)) begin
               state_d = c_ST_RUN;
            end
         end
         default: state_d = c_ST_RUN;
      endcase
   end

   always_comb begin
      w_load_ready = 1'b0;
      w_cpu_hold   = 1'b0;
      if (state_q == c_ST_LOAD) begin
         w_load_ready = 1'b1;
         w_cpu_hold   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            mem_q[i] <= RST_WORD;
         end
         wptr_q        <= '0;
         checksum_q    <= '0;
         fetch_data_q  <= '0;
         fetch_valid_q <= 1'b0;
         load_done_q   <= 1'b0;
         load_abort_q  <= 1'b0;
         armed_q       <= 1'b1;
      end else begin
         fetch_valid_q <= w_fetch;
         if (w_fetch) begin
            fetch_data_q <= mem_q[bus.fetch_addr];
         end
         load_done_q  <= w_wr && w_last;
         load_abort_q <= w_in_load && !bus.load_en;
         if (w_start) begin
            wptr_q     <= '0;
            checksum_q <= '0;
         end else if (w_wr) begin
            mem_q[wptr_q[AW-1:0]] <= bus.load_data;
            checksum_q            <= checksum_q ^ bus.load_data;
            wptr_q                <= wptr_q + c_PTR_ONE;
         end
         if (!bus.load_en) begin
            armed_q <= 1'b1;
         end else if (w_wr && w_last) begin
            armed_q <= 1'b0;
         end
      end
   end

   assign bus.load_ready  = w_load_ready;
   assign bus.cpu_hold    = w_cpu_hold;
   assign bus.load_done   = load_done_q;
   assign bus.load_abort  = load_abort_q;
   assign bus.fetch_data  = fetch_data_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.checksum    = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_td4_prog_rom.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_td4_prog_rom : directed scoreboard bench for td4_prog_rom         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_td4_prog_rom;
   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   td4_prog_rom_if #(.AW(AW), .DW(DW)) bus ();

   td4_prog_rom #(.AW(AW), .DW(DW), .RST_WORD(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model [DEPTH];
   logic [7:0] img   [DEPTH];
   logic [7:0] cks_m;
   logic [7:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_one(input int a);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = 4'(a);
      exp_q.push_back(model[a]);
      step();
      bus.fetch_req = 1'b0;
      chk("fetch_valid", 32'(bus.fetch_valid), 32'd1);
      chk("cpu_hold_run", 32'(bus.cpu_hold), 32'd0);
      if (exp_q.size() != 0) chk($sformatf("fetch_data[%0d]", a), 32'(bus.fetch_data), 32'(exp_q.pop_front()));
   endtask

   task automatic fetch_all();
      for (int a = 0; a < DEPTH; a++) fetch_one(a);
      step();
      chk("fetch_valid_idle", 32'(bus.fetch_valid), 32'd0);
   endtask

   task automatic load_image(input bit gaps, input bit hold_fetch);
      cks_m          = 8'h00;
      bus.load_en    = 1'b1;
      bus.load_valid = 1'b0;
      if (hold_fetch) begin
         bus.fetch_req  = 1'b1;
         bus.fetch_addr = 4'd2;
         exp_q.push_back(model[2]);
      end
      step();
      chk("cpu_hold_enter", 32'(bus.cpu_hold), 32'd1);
      chk("load_ready_enter", 32'(bus.load_ready), 32'd1);
      chk("checksum_cleared", 32'(bus.checksum), 32'd0);
      if (hold_fetch) begin
         chk("fetch_valid_on_entry", 32'(bus.fetch_valid), 32'd1);
         chk("fetch_data_on_entry", 32'(bus.fetch_data), 32'(exp_q.pop_front()));
      end
      for (int i = 0; i < DEPTH; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = img[i];
         model[i]       = img[i];
         cks_m          = cks_m ^ img[i];
         chk("load_ready_stream", 32'(bus.load_ready), 32'd1);
         chk("cpu_hold_stream", 32'(bus.cpu_hold), 32'd1);
         chk("load_done_early", 32'(bus.load_done), 32'd0);
         if (hold_fetch && i > 0) chk("fetch_valid_in_load", 32'(bus.fetch_valid), 32'd0);
         step();
         bus.load_valid = 1'b0;
         if (gaps && i < DEPTH - 1) begin
            chk("load_done_gap", 32'(bus.load_done), 32'd0);
            if (hold_fetch) chk("fetch_valid_gap", 32'(bus.fetch_valid), 32'd0);
            step();
         end
      end
      chk("load_done_pulse", 32'(bus.load_done), 32'd1);
      chk("cpu_hold_after_done", 32'(bus.cpu_hold), 32'd0);
      chk("load_ready_after_done", 32'(bus.load_ready), 32'd0);
      chk("checksum_full", 32'(bus.checksum), 32'(cks_m));
      if (hold_fetch) begin
         chk("fetch_valid_last_byte", 32'(bus.fetch_valid), 32'd0);
         exp_q.push_back(model[2]);
      end
      step();
      chk("load_done_single", 32'(bus.load_done), 32'd0);
      if (hold_fetch) begin
         bus.fetch_req = 1'b0;
         chk("fetch_valid_after_load", 32'(bus.fetch_valid), 32'd1);
         chk("fetch_data_after_load", 32'(bus.fetch_data), 32'(exp_q.pop_front()));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      bus.load_en    = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data  = 8'h00;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = 4'd0;
      for (int a = 0; a < DEPTH; a++) model[a] = 8'h00;

      rst = 1'b1;
      step();
      step();
      chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
      chk("rst_load_done", 32'(bus.load_done), 32'd0);
      chk("rst_load_abort", 32'(bus.load_abort), 32'd0);
      chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd0);
      chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
      chk("rst_fetch_data", 32'(bus.fetch_data), 32'd0);
      chk("rst_checksum", 32'(bus.checksum), 32'd0);
      rst = 1'b0;
      fetch_all();

      // Image A: contiguous stream, then load_en held high must not restart.
      for (int i = 0; i < DEPTH; i++) img[i] = 8'(i * 29 + 7);
      img[0] = 8'hB1;
      img[1] = 8'h01;
      load_image(1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("no_restart_hold", 32'(bus.cpu_hold), 32'd0);
         chk("no_restart_ready", 32'(bus.load_ready), 32'd0);
      end
      fetch_one(0);
      fetch_one(1);
      bus.load_en = 1'b0;
      step();

      // Image B: gapped stream with fetch_req held throughout.
      for (int i = 0; i < DEPTH; i++) img[i] = 8'(8'hC3 ^ (i * 13));
      load_image(1'b1, 1'b1);
      bus.load_en = 1'b0;
      step();
      fetch_all();

      // Full 0xFF image, then a 5-byte aborted download of 0x3C.
      for (int i = 0; i < DEPTH; i++) img[i] = 8'hFF;
      load_image(1'b0, 1'b0);
      bus.load_en = 1'b0;
      step();
      bus.load_en = 1'b1;
      step();
      chk("abort_hold_enter", 32'(bus.cpu_hold), 32'd1);
      cks_m = 8'h00;
      for (int i = 0; i < 5; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = 8'h3C;
         model[i]       = 8'h3C;
         cks_m          = cks_m ^ 8'h3C;
         step();
      end
      bus.load_valid = 1'b0;
      bus.load_en    = 1'b0;
      step();
      chk("abort_pulse", 32'(bus.load_abort), 32'd1);
      chk("abort_no_done", 32'(bus.load_done), 32'd0);
      chk("abort_hold_off", 32'(bus.cpu_hold), 32'd0);
      chk("abort_checksum", 32'(bus.checksum), 32'(cks_m));
      step();
      chk("abort_single", 32'(bus.load_abort), 32'd0);
      fetch_all();

      // Reset landing on byte 7 of a download.
      bus.load_en = 1'b1;
      step();
      for (int i = 0; i < 7; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = 8'(8'h55 + i);
         step();
      end
      bus.load_data = 8'hAA;
      bus.load_en   = 1'b0;
      rst           = 1'b1;
      step();
      rst            = 1'b0;
      bus.load_valid = 1'b0;
      chk("midrst_hold", 32'(bus.cpu_hold), 32'd0);
      chk("midrst_ready", 32'(bus.load_ready), 32'd0);
      chk("midrst_done", 32'(bus.load_done), 32'd0);
      chk("midrst_abort", 32'(bus.load_abort), 32'd0);
      chk("midrst_checksum", 32'(bus.checksum), 32'd0);
      step();
      chk("midrst_done_after", 32'(bus.load_done), 32'd0);
      chk("midrst_abort_after", 32'(bus.load_abort), 32'd0);
      for (int a = 0; a < DEPTH; a++) model[a] = 8'h00;
      fetch_all();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
